// File: rtl/dsram_responder_pkg.sv
// ============================================================================
// dsram_responder_pkg: MMIO map, read-source select and byte-merge helper
// Rev 1.0
// ============================================================================
`default_nettype none

package dsram_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;

  localparam logic [15:0] LED_OFF     = 16'h0000;
  localparam logic [15:0] SW_OFF      = 16'h0004;
  localparam logic [15:0] TIMER_OFF   = 16'h0008;
  localparam logic [15:0] CMP_OFF     = 16'h000C;
  localparam logic [15:0] SCRATCH_OFF = 16'h0010;

  typedef enum logic {
    SRC_REG = 1'b0,
    SRC_RAM = 1'b1
  } rd_src_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
    merge_bytes = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merge_bytes[8*i +: 8] = new_v[8*i +: 8];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/dsram_resp_ram.sv
// ============================================================================
// dsram_resp_ram: single-port 2^AW x 32 RAM, byte writes, registered
// read-before-write output. Rev 1.0
// ============================================================================
`default_nettype none

module dsram_resp_ram #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dsram_responder.sv
// ============================================================================
// dsram_responder: data_sram responder (RAM + LED/SWITCH/TIMER/SCRATCH MMIO).
// Optional TIMER_CMP + timer_irq via DSRAM_RESP_TIMER_IRQ_EN. Rev 1.0
// ============================================================================
`default_nettype none

module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int unsigned RAM_AW    = 12,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter int unsigned SW_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            data_sram_en,
  input  logic [3:0]      data_sram_wen,
  input  logic [31:0]     data_sram_addr,
  input  logic [31:0]     data_sram_wdata,
  output logic [31:0]     data_sram_rdata,
  output logic [15:0]     led,
  input  logic [SW_W-1:0] switch,
  output logic            timer_irq
);

  logic            w_mmio_sel;
  logic            w_rd;
  logic            w_wr;
  logic            w_mmio_wr;
  logic [13:0]     w_off;
  logic [31:0]     w_ram_rdata;
  logic [31:0]     w_mmio_rdata;
  logic [31:0]     w_cmp_rdata;
  logic            unused_ok;

  logic [15:0]     led_q, led_d;
  logic [31:0]     timer_q, timer_d;
  logic [31:0]     scratch_q, scratch_d;
  logic [SW_W-1:0] sw_meta_q, sw_sync_q;
  logic [31:0]     hold_q, hold_d;
  rd_src_e         src_q, src_d;

  assign w_mmio_sel = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign w_rd       = data_sram_en && (data_sram_wen == 4'b0000);
  assign w_wr       = data_sram_en && (data_sram_wen != 4'b0000);
  assign w_mmio_wr  = w_wr && w_mmio_sel;
  assign w_off      = data_sram_addr[15:2];
  assign unused_ok  = ^data_sram_addr[1:0];

  dsram_resp_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .clk     (clk),
    .en_i    (data_sram_en && !w_mmio_sel),
    .we_i    (data_sram_wen),
    .addr_i  (data_sram_addr[RAM_AW+1:2]),
    .wdata_i (data_sram_wdata),
    .rdata_o (w_ram_rdata)
  );

  always_comb begin
    led_d     = led_q;
    scratch_d = scratch_q;
    timer_d   = timer_q + 32'd1;
    if (w_mmio_wr) begin
      case (w_off)
        LED_OFF[15:2]:     led_d     = 16'(merge_bytes({16'h0000, led_q}, data_sram_wdata, data_sram_wen));
        TIMER_OFF[15:2]:   timer_d   = merge_bytes(timer_q, data_sram_wdata, data_sram_wen);
        SCRATCH_OFF[15:2]: scratch_d = merge_bytes(scratch_q, data_sram_wdata, data_sram_wen);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_mmio_rdata = 32'h0;
    case (w_off)
      LED_OFF[15:2]:     w_mmio_rdata = {16'h0000, led_q};
      SW_OFF[15:2]:      w_mmio_rdata = 32'(sw_sync_q);
      TIMER_OFF[15:2]:   w_mmio_rdata = timer_q;
      CMP_OFF[15:2]:     w_mmio_rdata = w_cmp_rdata;
      SCRATCH_OFF[15:2]: w_mmio_rdata = scratch_q;
      default: ;
    endcase
  end

  // RAM output changes on any RAM access, so on non-RAM-read cycles the
  // currently visible word is captured into hold_q to keep rdata stable.
  always_comb begin
    src_d  = SRC_REG;
    hold_d = data_sram_rdata;
    if (w_rd && !w_mmio_sel) begin
      src_d  = SRC_RAM;
      hold_d = hold_q;
    end else if (w_rd) begin
      hold_d = w_mmio_rdata;
    end
  end

  assign data_sram_rdata = (src_q == SRC_RAM) ? w_ram_rdata : hold_q;
  assign led             = led_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q     <= '0;
      timer_q   <= '0;
      scratch_q <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      hold_q    <= '0;
      src_q     <= SRC_REG;
    end else begin
      led_q     <= led_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      hold_q    <= hold_d;
      src_q     <= src_d;
    end
  end

`ifdef DSRAM_RESP_TIMER_IRQ_EN
  logic [31:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;
  logic        w_wr_cmp;

  assign w_wr_cmp = w_mmio_wr && (w_off == CMP_OFF[15:2]);

  // A compare write always clears the flag, even on a same-cycle match.
  always_comb begin
    cmp_d = cmp_q;
    irq_d = irq_q;
    if (w_wr_cmp) begin
      cmp_d = merge_bytes(cmp_q, data_sram_wdata, data_sram_wen);
      irq_d = 1'b0;
    end else if (timer_q == cmp_q) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      irq_q <= irq_d;
    end
  end

  assign w_cmp_rdata = cmp_q;
  assign timer_irq   = irq_q;
`else
  assign w_cmp_rdata = 32'h0;
  assign timer_irq   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dsram_responder.sv
// ============================================================================
// tb_dsram_responder: directed vector table plus reset/timer/irq sequences.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dsram_responder;

  localparam logic [31:0] B = 32'hBFAF_0000;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [7:0]  sw = 8'h5A;
  logic        irq;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  dsram_responder dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .led             (led),
    .switch          (sw),
    .timer_irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one access, clock it, then check outputs 1ns after the edge.
  task automatic step(input logic e, input logic [3:0] we, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd,
                      input int exp_led, input int exp_irq, input string nm);
    en = e; wen = we; addr = a; wdata = d;
    @(posedge clk);
    #1;
    chk({nm, ".rdata"}, rdata, exp_rd);
    if (exp_led >= 0) chk({nm, ".led"}, {16'h0, led}, exp_led[31:0]);
    if (exp_irq >= 0) chk({nm, ".irq"}, {31'h0, irq}, exp_irq[31:0]);
  endtask

  function automatic vec_t mk(input logic e, input logic [3:0] we, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] r, input logic [15:0] l);
    vec_t v;
    v.en = e; v.wen = we; v.addr = a; v.wdata = d; v.exp_rd = r; v.exp_led = l;
    return v;
  endfunction

  initial begin
    logic [31:0] held;
    int          irq_after_reset;

    vecs.push_back(mk(1, 4'hF, B+32'h00, 32'hFFFF_00AA, 32'h0000_0001, 16'h00AA));
    vecs.push_back(mk(1, 4'h0, B+32'h00, 32'h0,         32'h0000_00AA, 16'h00AA));
    vecs.push_back(mk(1, 4'hF, 32'h100,  32'h1122_3344, 32'h0000_00AA, 16'h00AA));
    vecs.push_back(mk(1, 4'h5, 32'h100,  32'hAABB_CCDD, 32'h0000_00AA, 16'h00AA));
    vecs.push_back(mk(1, 4'h0, 32'h100,  32'h0,         32'h11BB_33DD, 16'h00AA));
    vecs.push_back(mk(0, 4'hF, 32'h100,  32'h0,         32'h11BB_33DD, 16'h00AA));
    vecs.push_back(mk(1, 4'h0, 32'h100,  32'h0,         32'h11BB_33DD, 16'h00AA));
    vecs.push_back(mk(1, 4'hF, 32'h4,    32'hDEAD_BEEF, 32'h11BB_33DD, 16'h00AA));
    vecs.push_back(mk(1, 4'h0, 32'h0001_0004, 32'h0,    32'hDEAD_BEEF, 16'h00AA));
    vecs.push_back(mk(0, 4'h0, 32'h0,    32'h0,         32'hDEAD_BEEF, 16'h00AA));
    vecs.push_back(mk(1, 4'hF, 32'h4,    32'h0,         32'hDEAD_BEEF, 16'h00AA));
    vecs.push_back(mk(1, 4'h0, 32'h4,    32'h0,         32'h0000_0000, 16'h00AA));
    vecs.push_back(mk(1, 4'h0, 32'h100,  32'h0,         32'h11BB_33DD, 16'h00AA));
    vecs.push_back(mk(1, 4'h0, B+32'h04, 32'h0,         32'h0000_005A, 16'h00AA));
    vecs.push_back(mk(1, 4'hF, B+32'h04, 32'hFFFF_FFFF, 32'h0000_005A, 16'h00AA));
    vecs.push_back(mk(1, 4'h0, B+32'h04, 32'h0,         32'h0000_005A, 16'h00AA));
    vecs.push_back(mk(1, 4'hF, B+32'h20, 32'h1234_5678, 32'h0000_005A, 16'h00AA));
    vecs.push_back(mk(1, 4'h0, B+32'h20, 32'h0,         32'h0000_0000, 16'h00AA));
    vecs.push_back(mk(1, 4'hF, B+32'h10, 32'hCAFE_F00D, 32'h0000_0000, 16'h00AA));
    vecs.push_back(mk(1, 4'h8, B+32'h10, 32'h1111_1111, 32'h0000_0000, 16'h00AA));
    vecs.push_back(mk(1, 4'h0, B+32'h10, 32'h0,         32'h11FE_F00D, 16'h00AA));
    vecs.push_back(mk(1, 4'h2, B+32'h00, 32'h0000_5500, 32'h11FE_F00D, 16'h55AA));
    vecs.push_back(mk(1, 4'h0, B+32'h00, 32'h0,         32'h0000_55AA, 16'h55AA));
    vecs.push_back(mk(1, 4'h0, B+32'h0C, 32'h0,         32'h0000_0000, 16'h55AA));
    vecs.push_back(mk(1, 4'hF, 32'h3FFC, 32'hA5A5_A5A5, 32'h0000_0000, 16'h55AA));
    vecs.push_back(mk(1, 4'h0, 32'hFFFC, 32'h0,         32'hA5A5_A5A5, 16'h55AA));
    vecs.push_back(mk(1, 4'h0, 32'hBFAE_0100, 32'h0,    32'h11BB_33DD, 16'h55AA));
    vecs.push_back(mk(1, 4'h0, B+32'h00, 32'h0,         32'h0000_55AA, 16'h55AA));
    vecs.push_back(mk(1, 4'h0, B+32'h13, 32'h0,         32'h11FE_F00D, 16'h55AA));
    vecs.push_back(mk(1, 4'h0, 32'h102,  32'h0,         32'h11BB_33DD, 16'h55AA));

`ifdef DSRAM_RESP_TIMER_IRQ_EN
    held = 32'h0000_0064;
    irq_after_reset = 1;
`else
    held = 32'h0000_0077;
    irq_after_reset = 0;
`endif

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    chk("por.rdata", rdata, 32'h0);
    chk("por.led", {16'h0, led}, 32'h0);
    chk("por.irq", {31'h0, irq}, 32'h0);

    rst = 1'b1;
    step(1, 4'h0, B+32'h08, 32'h0, 32'h0000_0000, -1, -1, "por_timer0");
    step(1, 4'h0, B+32'h08, 32'h0, 32'h0000_0001, -1, -1, "por_timer1");
    step(0, 4'h0, 32'h0,    32'h0, 32'h0000_0001, -1, irq_after_reset, "por_irq");

    foreach (vecs[i])
      step(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_rd, int'(vecs[i].exp_led), -1, $sformatf("vec%0d", i));

    // Timer wrap, write priority and byte merge over the pre-increment value.
    step(1, 4'hF, B+32'h08, 32'hFFFF_FFFE, 32'h11BB_33DD, -1, -1, "tmr_wr");
    step(0, 4'h0, 32'h0,    32'h0,         32'h11BB_33DD, -1, -1, "tmr_idle");
    step(1, 4'h0, B+32'h08, 32'h0,         32'hFFFF_FFFF, -1, -1, "tmr_max");
    step(1, 4'h0, B+32'h08, 32'h0,         32'h0000_0000, -1, -1, "tmr_wrap");
    step(1, 4'hF, B+32'h08, 32'h0000_0005, 32'h0000_0000, -1, -1, "tmr_wr5");
    step(1, 4'h0, B+32'h08, 32'h0,         32'h0000_0005, -1, -1, "tmr_rd5");
    step(1, 4'h1, B+32'h08, 32'hFFFF_FF77, 32'h0000_0005, -1, -1, "tmr_wrb");
    step(1, 4'h0, B+32'h08, 32'h0,         32'h0000_0077, -1, -1, "tmr_rdb");

`ifdef DSRAM_RESP_TIMER_IRQ_EN
    step(1, 4'hF, B+32'h0C, 32'd100, 32'h0000_0077, -1, 0, "irq_cmp");
    step(1, 4'hF, B+32'h08, 32'd90,  32'h0000_0077, -1, 0, "irq_tmr");
    for (int k = 0; k < 10; k++)
      step(0, 4'h0, 32'h0, 32'h0, 32'h0000_0077, -1, 0, $sformatf("irq_wait%0d", k));
    step(0, 4'h0, 32'h0,    32'h0, 32'h0000_0077, -1, 1, "irq_rise");
    step(0, 4'h0, 32'h0,    32'h0, 32'h0000_0077, -1, 1, "irq_stay");
    step(1, 4'h0, B+32'h0C, 32'h0, 32'h0000_0064, -1, 1, "irq_rdcmp");
    step(1, 4'h4, B+32'h0C, 32'h0, 32'h0000_0064, -1, 0, "irq_clr");
    step(0, 4'h0, 32'h0,    32'h0, 32'h0000_0064, -1, 0, "irq_low");
`else
    step(0, 4'h0, 32'h0,    32'h0, 32'h0000_0077, -1, 0, "irq_tied");
`endif

    // Asynchronous reset asserted mid-run with LED = 0x00AA.
    step(1, 4'hF, B+32'h00, 32'h0000_00AA, held, 16'h00AA, -1, "mid_led");
    en = 1'b0;
    rst = 1'b0;
    #2;
    chk("mid_rst.led", {16'h0, led}, 32'h0);
    chk("mid_rst.rdata", rdata, 32'h0);
    chk("mid_rst.irq", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 4'h0, B+32'h08, 32'h0, 32'h0000_0000, 0, -1, "rel_timer0");
    step(1, 4'h0, B+32'h08, 32'h0, 32'h0000_0001, 0, -1, "rel_timer1");
    step(1, 4'h0, B+32'h00, 32'h0, 32'h0000_0000, 0, -1, "rel_led");
    step(1, 4'h0, B+32'h10, 32'h0, 32'h0000_0000, 0, -1, "rel_scratch");
    step(1, 4'h0, 32'h100,  32'h0, 32'h11BB_33DD, 0, irq_after_reset, "rel_ram");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
